// File: rtl/instruction_fetch_pkg.sv
// Shared widths, defaults and enums for the instruction fetch stage.
// Imported by the interface, the PC register and the fetch top.
package instruction_fetch_pkg;

    localparam int ADDR_W   = 8;
    localparam int INSTR_W  = 32;
    localparam int BUBBLE_W = 16;

    localparam logic [ADDR_W-1:0]  RESET_PC_DEFAULT = '0;
    localparam logic [INSTR_W-1:0] NOP_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALT   = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD   = 2'd0,
        PC_INC    = 2'd1,
        PC_TARGET = 2'd2
    } pc_sel_t;

    function automatic logic [BUBBLE_W-1:0] sat_inc(input logic [BUBBLE_W-1:0] v);
        return (v == {BUBBLE_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Bus between the fetch stage and its surroundings: instruction memory
// read port, control inputs from later stages and the IF/ID register.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic [ADDR_W-1:0]   o_imem_addr;
    logic [INSTR_W-1:0]  i_imem_instr;
    logic                i_stall;
    logic                i_redirect_valid;
    logic [ADDR_W-1:0]   i_redirect_target;
    logic                i_halt_req;
    logic [INSTR_W-1:0]  o_if_id_instr;
    logic [ADDR_W-1:0]   o_if_id_pc;
    logic                o_if_id_valid;
    logic                o_halted;
    logic [BUBBLE_W-1:0] o_bubble_count;

    modport master (
        output o_imem_addr,
        input  i_imem_instr,
        input  i_stall,
        input  i_redirect_valid,
        input  i_redirect_target,
        input  i_halt_req,
        output o_if_id_instr,
        output o_if_id_pc,
        output o_if_id_valid,
        output o_halted,
        output o_bubble_count
    );

    modport slave (
        input  o_imem_addr,
        output i_imem_instr,
        output i_stall,
        output i_redirect_valid,
        output i_redirect_target,
        output i_halt_req,
        input  o_if_id_instr,
        input  o_if_id_pc,
        input  o_if_id_valid,
        input  o_halted,
        input  o_bubble_count
    );

endinterface

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register with a hold / increment / load-target mux.
// Increment wraps modulo 2^ADDR_W; the target is loaded verbatim.
module fetch_pc_reg
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  pc_sel_t           i_sel,
    input  logic [ADDR_W-1:0] i_target,
    output logic [ADDR_W-1:0] o_pc
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;

    always_comb begin
        w_pc_next = r_pc;
        case (i_sel)
            PC_INC:    w_pc_next = r_pc + 1'b1;
            PC_TARGET: w_pc_next = i_target;
            default:   w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction memory address and
// registers the returned word with its PC into IF/ID for decode.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0]  RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_WORD_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_next;
    pc_sel_t             w_pc_sel;
    logic [ADDR_W-1:0]   w_pc;

    logic [INSTR_W-1:0]  r_if_id_instr;
    logic [ADDR_W-1:0]   r_if_id_pc;
    logic                r_if_id_valid;
    logic                r_halted;
    logic [BUBBLE_W-1:0] r_bubble_count;

    logic [INSTR_W-1:0]  w_if_id_instr_next;
    logic [ADDR_W-1:0]   w_if_id_pc_next;
    logic                w_if_id_valid_next;
    logic                w_halted_next;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clock    (clock),
        .reset    (reset),
        .i_sel    (w_pc_sel),
        .i_target (bus.i_redirect_target),
        .o_pc     (w_pc)
    );

    // The memory word seen at an edge always belongs to the current PC,
    // so a redirect only has to squash what would be captured now.
    always_comb begin
        w_state_next       = r_state;
        w_pc_sel           = PC_HOLD;
        w_if_id_instr_next = r_if_id_instr;
        w_if_id_pc_next    = r_if_id_pc;
        w_if_id_valid_next = r_if_id_valid;
        w_halted_next      = r_halted;

        case (r_state)
            ST_WARMUP: begin
                w_if_id_instr_next = NOP_WORD;
                w_if_id_valid_next = 1'b0;
                if (bus.i_redirect_valid) begin
                    w_pc_sel = PC_TARGET;
                end else if (bus.i_halt_req) begin
                    w_state_next  = ST_HALT;
                    w_halted_next = 1'b1;
                end else begin
                    w_state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.i_redirect_valid) begin
                    w_pc_sel           = PC_TARGET;
                    w_if_id_instr_next = NOP_WORD;
                    w_if_id_valid_next = 1'b0;
                end else if (bus.i_halt_req) begin
                    w_state_next       = ST_HALT;
                    w_halted_next      = 1'b1;
                    w_if_id_instr_next = NOP_WORD;
                    w_if_id_valid_next = 1'b0;
                end else if (!bus.i_stall) begin
                    w_pc_sel           = PC_INC;
                    w_if_id_instr_next = bus.i_imem_instr;
                    w_if_id_pc_next    = w_pc;
                    w_if_id_valid_next = 1'b1;
                end
            end

            ST_HALT: begin
                w_if_id_instr_next = NOP_WORD;
                w_if_id_valid_next = 1'b0;
                if (bus.i_redirect_valid) begin
                    w_pc_sel      = PC_TARGET;
                    w_state_next  = ST_WARMUP;
                    w_halted_next = 1'b0;
                end
            end

            default: begin
                w_state_next       = ST_WARMUP;
                w_if_id_instr_next = NOP_WORD;
                w_if_id_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state        <= ST_WARMUP;
            r_if_id_instr  <= NOP_WORD;
            r_if_id_pc     <= '0;
            r_if_id_valid  <= 1'b0;
            r_halted       <= 1'b0;
            r_bubble_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_if_id_instr <= w_if_id_instr_next;
            r_if_id_pc    <= w_if_id_pc_next;
            r_if_id_valid <= w_if_id_valid_next;
            r_halted      <= w_halted_next;
            if (!w_if_id_valid_next) begin
                r_bubble_count <= sat_inc(r_bubble_count);
            end
        end
    end

    assign bus.o_imem_addr    = w_pc;
    assign bus.o_if_id_instr  = r_if_id_instr;
    assign bus.o_if_id_pc     = r_if_id_pc;
    assign bus.o_if_id_valid  = r_if_id_valid;
    assign bus.o_halted       = r_halted;
    assign bus.o_bubble_count = r_bubble_count;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: negedge-updated memory model,
// hand-computed expectations after each posedge.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   n_step;

    logic [INSTR_W-1:0] mem [256];

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) bus.i_imem_instr <= mem[bus.o_imem_addr];

    function automatic logic [31:0] word_of(input logic [7:0] a);
        return (a == 8'd0) ? 32'hF040_0100 : {8'hC3, a, ~a, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        n_step++;
        $display("step %0d: addr=%0d if_id_pc=%0d instr=%h valid=%0b halted=%0b bubbles=%0d",
                 n_step, bus.o_imem_addr, bus.o_if_id_pc, bus.o_if_id_instr,
                 bus.o_if_id_valid, bus.o_halted, bus.o_bubble_count);
    endtask

    task automatic chk_cap(input string tag, input logic [7:0] pc, input logic [7:0] next_addr);
        chk({tag, "_valid"}, 32'(bus.o_if_id_valid), 32'd1);
        chk({tag, "_pc"},    32'(bus.o_if_id_pc), 32'(pc));
        chk({tag, "_instr"}, bus.o_if_id_instr, word_of(pc));
        chk({tag, "_addr"},  32'(bus.o_imem_addr), 32'(next_addr));
    endtask

    task automatic chk_bub(input string tag, input logic [7:0] addr, input int bubbles, input logic halted);
        chk({tag, "_valid"},  32'(bus.o_if_id_valid), 32'd0);
        chk({tag, "_instr"},  bus.o_if_id_instr, 32'h0);
        chk({tag, "_addr"},   32'(bus.o_imem_addr), 32'(addr));
        chk({tag, "_bubble"}, 32'(bus.o_bubble_count), 32'(bubbles));
        chk({tag, "_halted"}, 32'(bus.o_halted), 32'(halted));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        n_step   = 0;
        for (int i = 0; i < 256; i++) mem[i] = word_of(8'(i));
        reset                 = 1'b1;
        bus.i_stall           = 1'b0;
        bus.i_redirect_valid  = 1'b0;
        bus.i_redirect_target = '0;
        bus.i_halt_req        = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk_bub("reset", 8'd0, 0, 1'b0);
        chk("reset_if_id_pc", 32'(bus.o_if_id_pc), 32'd0);

        @(negedge clock);
        reset = 1'b0;
        step();
        chk_bub("warmup", 8'd0, 1, 1'b0);
        step(); chk_cap("cap0", 8'd0, 8'd1);
        step(); chk_cap("cap1", 8'd1, 8'd2);
        step(); chk_cap("cap2", 8'd2, 8'd3);
        step(); chk_cap("cap3", 8'd3, 8'd4);
        step(); chk_cap("cap4", 8'd4, 8'd5);

        bus.i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_cap("stall", 8'd4, 8'd5);
            chk("stall_bubble", 32'(bus.o_bubble_count), 32'd1);
        end
        bus.i_stall = 1'b0;
        step(); chk_cap("unstall", 8'd5, 8'd6);
        step(); chk_cap("cap6", 8'd6, 8'd7);

        bus.i_redirect_valid  = 1'b1;
        bus.i_redirect_target = 8'd50;
        step(); chk_bub("redir50", 8'd50, 2, 1'b0);
        bus.i_redirect_valid = 1'b0;
        step(); chk_cap("tgt50", 8'd50, 8'd51);

        bus.i_stall           = 1'b1;
        bus.i_redirect_valid  = 1'b1;
        bus.i_redirect_target = 8'd254;
        step(); chk_bub("redir_stall", 8'd254, 3, 1'b0);
        bus.i_redirect_valid = 1'b0;
        step(); chk_bub("stall_bubble_hold", 8'd254, 4, 1'b0);
        bus.i_stall = 1'b0;
        step(); chk_cap("cap254", 8'd254, 8'd255);
        step(); chk_cap("cap255", 8'd255, 8'd0);
        step(); chk_cap("wrap0", 8'd0, 8'd1);

        bus.i_redirect_valid  = 1'b1;
        bus.i_redirect_target = 8'd105;
        step(); chk_bub("redir105", 8'd105, 5, 1'b0);
        bus.i_redirect_valid = 1'b0;
        bus.i_halt_req       = 1'b1;
        step(); chk_bub("halt", 8'd105, 6, 1'b1);
        bus.i_halt_req = 1'b0;
        bus.i_stall    = 1'b1;
        step(); chk_bub("halted1", 8'd105, 7, 1'b1);
        step(); chk_bub("halted2", 8'd105, 8, 1'b1);
        bus.i_stall           = 1'b0;
        bus.i_redirect_valid  = 1'b1;
        bus.i_redirect_target = 8'd0;
        step(); chk_bub("unhalt", 8'd0, 9, 1'b0);
        bus.i_redirect_valid = 1'b0;
        step(); chk_bub("rewarm", 8'd0, 10, 1'b0);
        step(); chk_cap("resume0", 8'd0, 8'd1);
        step(); chk_cap("resume1", 8'd1, 8'd2);

        // Reset between edges must act before the next posedge.
        #3;
        reset = 1'b1;
        #1;
        chk_bub("async_reset", 8'd0, 0, 1'b0);
        chk("async_reset_if_id_pc", 32'(bus.o_if_id_pc), 32'd0);

        @(negedge clock);
        reset                 = 1'b0;
        bus.i_redirect_valid  = 1'b1;
        bus.i_redirect_target = 8'd20;
        step(); chk_bub("warm_redir", 8'd20, 1, 1'b0);
        bus.i_redirect_valid = 1'b0;
        step(); chk_bub("warm_again", 8'd20, 2, 1'b0);
        step(); chk_cap("cap20", 8'd20, 8'd21);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage that drives the instruction memory read port and owns the program counter. Presents an 8-bit address, captures the 32-bit word returned on the following clock, and registers it with its PC into the IF/ID pipeline register for decode. Handles stall, branch/jump redirect, squash and halt, and supplies the datapath front end.

Parameters:
ADDR_W, 8, program counter and memory address width.
INSTR_W, 32, instruction width.
RESET_PC, 0, PC value loaded on reset.
NOP_WORD, 32'h0000_0000, word inserted on bubble or squash.

Ports:
clock  in  1  single system clock; all state updates on posedge.
reset  in  1  asynchronous, active-high reset.
imem_addr  out  ADDR_W  read address to instruction memory; equals the PC register, no combinational path from inputs.
imem_instr  in  INSTR_W  memory read data; updated by memory on negedge, valid at next posedge.
stall  in  1  hold PC and IF/ID contents.
redirect_valid  in  1  branch/jump taken this cycle.
redirect_target  in  ADDR_W  new PC on redirect.
halt_req  in  1  stop fetching.
if_id_instr  out  INSTR_W  registered instruction to decode.
if_id_pc  out  ADDR_W  PC of if_id_instr.
if_id_valid  out  1  if_id_instr is a real fetched instruction.
halted  out  1  high while in HALT.
bubble_count  out  16  saturating count of cycles with if_id_valid=0 since reset.

Behaviour:
- Reset (async, while high): pc=RESET_PC, imem_addr=RESET_PC, if_id_instr=NOP_WORD, if_id_pc=0, if_id_valid=0, halted=0, bubble_count=0, state=WARMUP.
- Timing: PC changes at posedge t; memory samples on negedge t+0.5; word for that PC is captured at posedge t+1. One-cycle fetch latency.
- States: WARMUP, RUN, HALT.
- WARMUP: exactly one cycle after reset release; memory output not yet trusted. No capture, IF/ID stays NOP/valid=0, pc unchanged, -> RUN. redirect_valid here: pc<=target, stay one more cycle in WARMUP. halt_req here -> HALT.
- RUN, priority redirect > halt > stall > normal:
  - redirect_valid: pc<=redirect_target; IF/ID<=NOP_WORD, valid=0 (wrong-path word squashed). Next posedge captures the target word. Penalty exactly one bubble. Applies even when stall=1.
  - halt_req: -> HALT; IF/ID<=NOP, valid=0; pc held.
  - stall: pc and all IF/ID outputs hold unchanged, including valid.
  - normal: if_id_instr<=imem_instr, if_id_pc<=pc, if_id_valid<=1, pc<=pc+1.
- HALT: halted=1; pc and IF/ID (NOP, valid=0) frozen; stall and halt_req ignored. Only exits: reset, or redirect_valid -> pc<=target, go to WARMUP (memory read settles), halted<=0.
- Arithmetic: pc+1 modulo 2^ADDR_W (255 -> 0, no flag). redirect_target used verbatim.
- bubble_count increments on each posedge where the newly registered if_id_valid is 0; saturates at 16'hFFFF; unaffected by stall-hold cycles that keep valid=1.
- Reset asserted mid-operation: immediate return to reset values regardless of state; in-flight word discarded.

Decomposition:
- Shared package: ADDR_W/INSTR_W constants, NOP_WORD, fetch-state enum {WARMUP, RUN, HALT}.
- One natural sub-module: fetch_pc_reg (PC register + next-PC mux: hold / +1 / target). The IF/ID register and FSM stay in the top.

Test Plan:
- Reset release with memory word 0 = 32'hF040_0100 -> one WARMUP cycle valid=0, then if_id_instr=32'hF040_0100, if_id_pc=0, valid=1; PC advances 1,2,3 on successive cycles.
- Stall high 3 cycles at pc=5 -> imem_addr stays 5, IF/ID unchanged 3 cycles; on release captures word 5, pc=6.
- redirect_valid with target=50 at pc=7 -> next IF/ID is NOP/valid=0, following cycle if_id_pc=50 with word 50; bubble_count +1; redirect and stall together -> redirect wins.
- pc=255, no stall -> if_id_pc=255, then pc wraps to 0, following capture if_id_pc=0.
- halt_req at pc=105 -> halted=1, IF/ID NOP valid=0 indefinitely, stall ignored; redirect target=0 -> WARMUP one cycle, then word 0 with valid=1, halted=0.
- Reset asserted between posedges mid-RUN -> outputs to reset values asynchronously (before next edge), imem_addr=0.
